// File: rtl/ddr_rd_channel_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_rd_channel_sched
//  Purpose  : Round-robin arbiter sharing one DDR read engine among slave
//             read channels, with a watchdog for a hung engine.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_rd_channel_sched #(
    parameter int CH_NUM  = 9,
    parameter int CH_W    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] ch_req,
    input  logic [CH_NUM-1:0] ch_en,
    input  logic              rd_idle,
    input  logic              rd_done,
    output logic              rd_start,
    output logic [CH_W-1:0]   read_channal,
    output logic [CH_NUM-1:0] ch_ack,
    output logic              busy,
    output logic              timeout_err
);

    localparam int c_wd_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_wd_w-1:0] c_wd_term = c_wd_w'(TIMEOUT - 1);
    localparam logic [CH_W-1:0]   c_ptr_rst = CH_W'(CH_NUM - 1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_arb   = 3'd1;
    localparam logic [2:0] c_start = 3'd2;
    localparam logic [2:0] c_wait  = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [CH_W-1:0]   r_ptr;
    logic [c_wd_w-1:0] r_wd;
    logic [CH_W-1:0]   r_read_channal;
    logic              r_rd_start;
    logic [CH_NUM-1:0] r_ch_ack;
    logic              r_busy;
    logic              r_timeout_err;

    logic [CH_NUM-1:0] w_elig;
    logic              w_grant_found;
    logic [CH_W-1:0]   w_grant_idx;
    logic              w_wd_term;
    logic [CH_NUM-1:0] w_ack_onehot;

    assign w_elig       = ch_req & ch_en;
    assign w_wd_term    = (r_wd == c_wd_term);
    assign w_ack_onehot = CH_NUM'(1) << r_read_channal;

    // Search starts one past the last grant and wraps at CH_NUM-1.
    always_comb begin : p_rr_search
        int              cand;
        logic [CH_W-1:0] cand_idx;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        cand          = 0;
        cand_idx      = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            cand = int'(r_ptr) + i;
            if (cand >= CH_NUM) begin
                cand = cand - CH_NUM;
            end
            cand_idx = CH_W'(cand);
            if (!w_grant_found && w_elig[cand_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_grant_found && rd_idle) begin
                    w_next_state = c_arb;
                end
            end
            c_arb:   w_next_state = c_start;
            c_start: w_next_state = c_wait;
            c_wait: begin
                // A completion in the terminal-count cycle still counts as done.
                if (rd_done) begin
                    w_next_state = c_done;
                end else if (w_wd_term) begin
                    w_next_state = c_idle;
                end
            end
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= c_ptr_rst;
            r_wd           <= '0;
            r_read_channal <= '0;
            r_rd_start     <= 1'b0;
            r_ch_ack       <= '0;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            r_rd_start    <= (r_state == c_start);
            r_ch_ack      <= '0;
            r_timeout_err <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_grant_found && rd_idle) begin
                        r_read_channal <= w_grant_idx;
                        r_busy         <= 1'b1;
                    end
                end
                c_start: begin
                    r_wd <= '0;
                end
                c_wait: begin
                    if (rd_done) begin
                        r_ch_ack <= w_ack_onehot;
                    end else if (w_wd_term) begin
                        // Advance the pointer so a hung channel cannot starve others.
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_ptr         <= r_read_channal;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                c_done: begin
                    r_ptr  <= r_read_channal;
                    r_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign rd_start     = r_rd_start;
    assign read_channal = r_read_channal;
    assign ch_ack       = r_ch_ack;
    assign busy         = r_busy;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_channel_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_rd_channel_sched
//  Purpose  : Directed self-checking bench for ddr_rd_channel_sched.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_rd_channel_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] ch_req = '0;
    logic [8:0] ch_en = '0;
    logic       rd_idle = 1'b0;
    logic       rd_done = 1'b0;
    logic       rd_start;
    logic [3:0] read_channal;
    logic [8:0] ch_ack;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int failures = 0;

    ddr_rd_channel_sched #(
        .CH_NUM  (9),
        .CH_W    (4),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_req       (ch_req),
        .ch_en        (ch_en),
        .rd_idle      (rd_idle),
        .rd_done      (rd_done),
        .rd_start     (rd_start),
        .read_channal (read_channal),
        .ch_ack       (ch_ack),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        ch_req  = '0;
        rd_done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Stimulus only: waits for rd_start, returns the granted channel and the
    // ack observed one cycle after rd_done; ch = -1 if rd_start never comes.
    task automatic run_txn(input int dly, output int ch, output logic [8:0] ack);
        ch  = -1;
        ack = '0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rd_start === 1'b1) begin
                ch = int'(read_channal);
                break;
            end
        end
        if (ch < 0) return;
        repeat (dly) tick();
        rd_done = 1'b1;
        tick();
        ack     = ch_ack;
        rd_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_req = '0; ch_en = '0; rd_idle = 1'b0; rd_done = 1'b0;
        repeat (3) tick();
        checks++; if (read_channal !== 4'd0) begin failures++; $display("FAIL reset_read_channal actual=%0d expected=0", read_channal); end
        checks++; if (rd_start !== 1'b0) begin failures++; $display("FAIL reset_rd_start actual=%b expected=0", rd_start); end
        checks++; if (ch_ack !== 9'h000) begin failures++; $display("FAIL reset_ch_ack actual=%h expected=000", ch_ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err actual=%b expected=0", timeout_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        ch_en = 9'h1FF; rd_idle = 1'b1; ch_req = 9'h001;
        tick();
        checks++; if (read_channal !== 4'd0) begin failures++; $display("FAIL single_grant actual=%0d expected=0", read_channal); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_hi actual=%b expected=1", busy); end
        tick();
        checks++; if (rd_start !== 1'b0) begin failures++; $display("FAIL single_start_early actual=%b expected=0", rd_start); end
        tick();
        checks++; if (rd_start !== 1'b1) begin failures++; $display("FAIL single_start actual=%b expected=1", rd_start); end
        ch_req = '0;
        tick();
        checks++; if (rd_start !== 1'b0) begin failures++; $display("FAIL single_start_width actual=%b expected=0", rd_start); end
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        checks++; if (ch_ack !== 9'h001) begin failures++; $display("FAIL single_ack actual=%h expected=001", ch_ack); end
        tick();
        checks++; if (ch_ack !== 9'h000) begin failures++; $display("FAIL single_ack_width actual=%h expected=000", ch_ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_lo actual=%b expected=0", busy); end
    endtask

    task automatic test_round_robin();
        int         ch;
        logic [8:0] ack;
        int         acked [9];
        apply_reset();
        for (int c = 0; c < 9; c++) acked[c] = 0;
        ch_en = 9'h1FF; rd_idle = 1'b1; ch_req = 9'h1FF;
        for (int i = 0; i < 10; i++) begin
            run_txn(0, ch, ack);
            if (i == 9) ch_req = '0;
            checks++; if (ch !== (i % 9)) begin failures++; $display("FAIL rr_grant[%0d] actual=%0d expected=%0d", i, ch, i % 9); end
            if (i < 9) for (int c = 0; c < 9; c++) if (ack[c]) acked[c]++;
        end
        for (int c = 0; c < 9; c++) begin
            checks++; if (acked[c] !== 1) begin failures++; $display("FAIL rr_ack_count[%0d] actual=%0d expected=1", c, acked[c]); end
        end
    endtask

    task automatic test_masked();
        int         ch;
        logic [8:0] ack;
        int         exp_ch;
        ch_req = 9'h0A4; ch_en = 9'h0A0;
        for (int i = 0; i < 4; i++) begin
            exp_ch = (i % 2 == 0) ? 5 : 7;
            run_txn(1, ch, ack);
            if (i == 3) ch_req = '0;
            checks++; if (ch !== exp_ch) begin failures++; $display("FAIL masked_grant[%0d] actual=%0d expected=%0d", i, ch, exp_ch); end
        end
        ch_en = 9'h1FF;
    endtask

    task automatic test_timeout();
        int         ch;
        logic [8:0] ack;
        int         cnt;
        int         acks;
        int         seen;
        ch_req = 9'h010;
        seen   = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rd_start === 1'b1) begin seen = 1; break; end
        end
        ch_req = '0;
        checks++; if (seen !== 1 || read_channal !== 4'd4) begin failures++; $display("FAIL to_grant actual=%0d seen=%0d expected=4", read_channal, seen); end
        cnt  = 0;
        acks = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ch_ack !== 9'h000) acks++;
            if (timeout_err === 1'b1) begin cnt = n; break; end
        end
        checks++; if (cnt !== 16) begin failures++; $display("FAIL to_latency actual=%0d expected=16", cnt); end
        checks++; if (acks !== 0) begin failures++; $display("FAIL to_no_ack actual=%0d expected=0", acks); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_busy actual=%b expected=0", busy); end
        tick();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse_width actual=%b expected=0", timeout_err); end
        ch_req = 9'h010;
        for (int i = 0; i < 2; i++) begin
            run_txn(2, ch, ack);
            if (i == 1) ch_req = '0;
            checks++; if (ch !== 4) begin failures++; $display("FAIL to_regrant[%0d] actual=%0d expected=4", i, ch); end
            checks++; if (ack !== 9'h010) begin failures++; $display("FAIL to_regrant_ack[%0d] actual=%h expected=010", i, ack); end
        end
    endtask

    task automatic test_spurious_done();
        int acks;
        ch_req = '0; rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        checks++; if (ch_ack !== 9'h000 || busy !== 1'b0) begin failures++; $display("FAIL sp_idle actual=ack %h busy %b expected=000/0", ch_ack, busy); end
        ch_req = 9'h008;
        tick();
        checks++; if (read_channal !== 4'd3) begin failures++; $display("FAIL sp_grant actual=%0d expected=3", read_channal); end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0; ch_req = '0;
        checks++; if (ch_ack !== 9'h000) begin failures++; $display("FAIL sp_arb_ack actual=%h expected=000", ch_ack); end
        tick();
        checks++; if (rd_start !== 1'b1) begin failures++; $display("FAIL sp_start actual=%b expected=1", rd_start); end
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        checks++; if (ch_ack !== 9'h008) begin failures++; $display("FAIL sp_ack actual=%h expected=008", ch_ack); end
        acks = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (ch_ack !== 9'h000) acks++;
        end
        checks++; if (acks !== 0) begin failures++; $display("FAIL sp_extra_ack actual=%0d expected=0", acks); end
    endtask

    task automatic test_reset_mid();
        int         ch;
        logic [8:0] ack;
        ch_req = 9'h040;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rd_start === 1'b1) break;
        end
        ch_req = '0;
        checks++; if (read_channal !== 4'd6) begin failures++; $display("FAIL rm_grant actual=%0d expected=6", read_channal); end
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (read_channal !== 4'd0 || busy !== 1'b0 || rd_start !== 1'b0) begin failures++; $display("FAIL rm_async actual=ch %0d busy %b start %b expected=0/0/0", read_channal, busy, rd_start); end
        checks++; if (ch_ack !== 9'h000 || timeout_err !== 1'b0) begin failures++; $display("FAIL rm_async_flags actual=ack %h to %b expected=000/0", ch_ack, timeout_err); end
        tick();
        ch_req = 9'h1C0;
        rst_n  = 1'b1;
        tick();
        checks++; if (read_channal !== 4'd6) begin failures++; $display("FAIL rm_first_grant actual=%0d expected=6", read_channal); end
        run_txn(0, ch, ack);
        checks++; if (ch !== 6 || ack !== 9'h040) begin failures++; $display("FAIL rm_txn6 actual=ch %0d ack %h expected=6/040", ch, ack); end
        run_txn(0, ch, ack);
        ch_req = '0;
        checks++; if (ch !== 7 || ack !== 9'h080) begin failures++; $display("FAIL rm_txn7 actual=ch %0d ack %h expected=7/080", ch, ack); end
    endtask

    task automatic test_all_disabled();
        int act;
        ch_en = '0; ch_req = 9'h1FF; rd_idle = 1'b1;
        act = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (busy !== 1'b0 || rd_start !== 1'b0 || ch_ack !== 9'h000) act++;
        end
        ch_req = '0;
        checks++; if (act !== 0) begin failures++; $display("FAIL disabled_activity actual=%0d expected=0", act); end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_masked();
        test_timeout();
        test_spurious_done();
        test_reset_mid();
        test_all_disabled();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_rd_channel_sched.md
Name: ddr_rd_channel_sched

Overview:
Round-robin scheduler that shares the single DDR read engine between up to 9 slave read channels. It drives read_channal, the select for the per-slave rd_load/rd_bank mux. It issues one read transaction per grant to the engine and returns a completion pulse to the granted slave. A watchdog recovers the scheduler if the engine never reports done.

Parameters:
CH_NUM, 9, number of slave read channels (1..16)
CH_W, 4, width of read_channal
TIMEOUT, 65535, WAIT-state cycles before abort

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
ch_req  input  CH_NUM  level request per channel (slave has a bank ready to read)
ch_en  input  CH_NUM  per-channel enable mask; 0 = never granted
rd_idle  input  1  DDR read engine ready for a new transaction
rd_done  input  1  one-cycle pulse, engine finished current transaction
rd_start  output  1  one-cycle pulse, start transaction on selected channel
read_channal  output  CH_W  granted channel index, drives the rd_load/rd_bank select mux
ch_ack  output  CH_NUM  one-hot one-cycle pulse to the granted channel on normal completion
busy  output  1  high from grant until return to IDLE
timeout_err  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset values (async, rst_n=0): state IDLE; read_channal=0; rd_start=0; ch_ack=0; busy=0; timeout_err=0; last-grant pointer=CH_NUM-1, so ch0 has first priority; watchdog=0.
- Eligible vector: elig = ch_req & ch_en.
- FSM states: IDLE, ARB, START, WAIT, DONE.
- IDLE:
  - If elig!=0 and rd_idle=1, compute the grant by round-robin search starting at pointer+1, wrapping at CH_NUM-1 -> 0.
  - Register the grant into read_channal, set busy=1, go to ARB.
  - Otherwise stay in IDLE.
- ARB: one settle cycle so the downstream mux output (rd_load/rd_bank) is stable. Go to START.
- START: rd_start=1 for exactly this cycle; clear the watchdog; go to WAIT.
- WAIT:
  - Increment the watchdog each cycle.
  - On rd_done=1, go to DONE.
  - If the watchdog reaches TIMEOUT-1 without rd_done, pulse timeout_err for 1 cycle and go to IDLE. No ch_ack is issued, but the pointer still advances, so a hung channel cannot starve the others.
- DONE: ch_ack[read_channal]=1 for 1 cycle; pointer <= read_channal; busy=0; go to IDLE.
- Latency: elig seen in IDLE at edge k -> read_channal valid after edge k -> rd_start high in the cycle after edge k+2. Minimum grant-to-grant spacing is 5 cycles including a 1-cycle rd_done.
- read_channal holds constant from ARB through DONE; it changes only on the IDLE->ARB transition. It never exceeds CH_NUM-1. In IDLE it keeps the last granted value.
- A slave dropping ch_req or ch_en after grant does not abort the transaction; it runs to done or timeout.
- rd_done arriving in IDLE, ARB or START (spurious or early) is ignored. Only WAIT samples it.
- rd_done and the watchdog terminal count in the same cycle: rd_done wins (DONE, ack, no timeout_err).
- Only one requester eligible: that channel is re-granted back-to-back regardless of the pointer.
- ch_en=0 on all channels: the block stays in IDLE indefinitely, outputs idle.
- Reset asserted mid-transaction: immediate return to reset values; no ack, no timeout_err.
- Output registration: all outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then ch_req=9'h001, ch_en=9'h1FF, rd_idle=1, rd_done 3 cycles after rd_start -> read_channal=0, single rd_start pulse 2 cycles after grant, ch_ack=9'h001 one cycle after rd_done, busy low afterwards.
- ch_req=9'h1FF held, rd_done always returned -> grants cycle 0,1,2,...,8,0; each channel acked exactly once per 9 transactions.
- ch_req=9'h0A4, ch_en=9'h0A0 -> only channels 5 and 7 granted, alternating 5,7,5,7; channel 2 is never granted.
- ch_req=9'h010, rd_done never returned, TIMEOUT=16 -> timeout_err pulses exactly once, 16 cycles after rd_start; no ch_ack; next grant proceeds normally.
- Spurious rd_done pulse in IDLE and in ARB, then a valid one in WAIT -> exactly one ch_ack; the state sequence is unaffected.
- rst_n pulled low during WAIT with read_channal=6 -> all outputs return to reset values at once; after release, ch_req=9'h1C0 grants channel 6 first (pointer reset to 8, search starts at 0).
